fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, giving the program counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 32, giving the instruction width.
REQ-003 SHALL have parameter PC_STEP, default 4, giving the sequential PC increment.
REQ-004 SHALL have parameter RESET_PC, default 0, giving the PC loaded by reset.
REQ-005 SHALL have parameter DEPTH, default 4, giving the number of fetch-queue entries; it SHALL be a power of two and at least 2.
REQ-006 SHALL have port clk  input  1  clock; every flop SHALL update on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; it is synchronous and active-high.
REQ-008 SHALL have port redirect_valid  input  1  branch taken / flush request.
REQ-009 SHALL have port redirect_pc  input  PC_W  branch target.
REQ-010 SHALL have port imem_req_valid  output  1  fetch request.
REQ-011 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-012 SHALL have port imem_req_addr  output  PC_W  fetch address.
REQ-013 SHALL have port imem_rsp_valid  input  1  in-order response; cannot be backpressured.
REQ-014 SHALL have port imem_rsp_instr  input  INSTR_W  returned instruction.
REQ-015 SHALL have port out_valid  output  1  instruction available to decode.
REQ-016 SHALL have port out_ready  input  1  decode accepts the instruction (deasserted means freeze).
REQ-017 SHALL have port out_instr  output  INSTR_W  instruction.
REQ-018 SHALL have port out_pc  output  PC_W  PC of out_instr.
REQ-019 SHALL have port out_pc_next  output  PC_W  out_pc+PC_STEP, modulo 2^PC_W.

Function
REQ-020 Fetch PC register pc_q SHALL drive imem_req_addr; on a request fire (valid&ready) it SHALL advance by PC_STEP, wrapping modulo 2^PC_W.
REQ-021 imem_req_valid SHALL be 1 only when rst=0, redirect_valid=0, and (allocated entries + discard_cnt) < DEPTH.
REQ-022 Each request fire SHALL allocate the queue entry at alloc_ptr, storing its PC and marking it unfilled.
REQ-023 Each response with discard_cnt=0 SHALL fill the oldest unfilled entry (fill_ptr) with imem_rsp_instr; a response with no unfilled entry SHALL be ignored.
REQ-024 out_valid SHALL be 1 when the head entry is allocated and filled and redirect_valid=0; out_instr/out_pc SHALL come from the head entry.
REQ-025 An out fire (valid&ready) SHALL free the head entry; out_valid with out_ready=0 SHALL keep all out_* stable.
REQ-026 Allocation, fill and free SHALL be able to occur in the same cycle, including when the queue is full or empty.
REQ-027 Minimum latency SHALL be: response at cycle N makes out_valid=1 at cycle N+1; no combinational path from imem_rsp_* to out_*.
REQ-028 On redirect_valid=1: pc_q SHALL load redirect_pc, all entries SHALL be invalidated, all pointers SHALL be zeroed, and no request SHALL issue that cycle.
REQ-029 On redirect, discard_cnt SHALL load the number of unfilled allocated entries minus any response arriving that cycle.
REQ-030 While discard_cnt>0, each response SHALL be dropped and discard_cnt SHALL decrement by 1.
REQ-031 A redirect coinciding with a request fire SHALL count that request into discard_cnt.
REQ-032 Back-to-back redirects SHALL each take effect, with the last target winning.

Reset
REQ-033 While rst=1: pc_q=RESET_PC, all pointers and counts 0, discard_cnt=0, imem_req_valid=0, out_valid=0, and out_instr/out_pc/out_pc_next=0; responses SHALL be ignored.
REQ-034 Reset SHALL override redirect; the first request SHALL issue in the cycle after rst falls, at address RESET_PC.

Structure
REQ-035 A shared package fetch_pkg SHALL hold the parameter defaults and the queue entry struct (pc, instr, filled).
REQ-036 Queue storage and pointers SHALL form one sub-module, fetch_queue; the PC, request and discard logic SHALL live in fetch_unit.

Verification
REQ-037 Reset, then zero-latency memory with out_ready=1 -> out_pc sequence 0,4,8,... with one instruction per cycle after a 2-cycle fill.
REQ-038 Hold out_ready=0 -> exactly 4 requests issue, then imem_req_valid=0; out_* stable; release -> 4 in-order outputs, then fetch resumes.
REQ-039 Redirect to 0x0100 with 3 requests outstanding -> next 3 responses dropped; first out_pc=0x0100, out_pc_next=0x0104.
REQ-040 RESET_PC=0xFFFC with PC_W=16 -> out_pc 0xFFFC then 0x0000; out_pc_next of the first instruction =0x0000.
REQ-041 Assert rst mid-stream with the queue full -> out_valid=0 next cycle; first request after release at RESET_PC; stale responses ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the fetch-queue entry layout for the
// instruction fetch unit.
//   FETCH_*        : default parameter values used by fetch_unit/fetch_queue
//   fetch_entry_t  : one queue entry (pc, instr, filled) at default widths
package fetch_pkg;

  localparam int FETCH_PC_W     = 16;
  localparam int FETCH_INSTR_W  = 32;
  localparam int FETCH_PC_STEP  = 4;
  localparam int FETCH_RESET_PC = 0;
  localparam int FETCH_DEPTH    = 4;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
    logic                     filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch queue. Entries are allocated when a request is
// issued (PC known, instruction pending), filled in order as responses return,
// and freed from the head when decode takes the instruction.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   flush_i             : drop all entries and zero pointers
//   alloc_i, alloc_pc_i : allocate the entry at the alloc pointer with this PC
//   fill_i, fill_instr_i: fill the oldest unfilled entry (ignored if none)
//   free_i              : release the head entry
//   head_ready_o        : head entry allocated and filled
//   head_pc_o/instr_o   : head entry contents
//   count_o, unfilled_o : allocated entries / allocated-but-unfilled entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_W    = FETCH_PC_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH   = FETCH_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alloc_i,
  input  logic [PC_W-1:0]            alloc_pc_i,
  input  logic                       fill_i,
  input  logic [INSTR_W-1:0]         fill_instr_i,
  input  logic                       free_i,
  output logic                       head_ready_o,
  output logic [PC_W-1:0]            head_pc_o,
  output logic [INSTR_W-1:0]         head_instr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     unfilled_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Same layout as fetch_entry_t, resized to this instance's widths.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } entry_t;

  entry_t        ent_q [DEPTH];
  logic [AW-1:0] head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CW-1:0] count_q, count_d, unfilled_q, unfilled_d;
  logic          fill_en;

  // A response with nothing outstanding in the queue is simply dropped.
  assign fill_en = fill_i && (unfilled_q != '0);

  // Alloc, fill and free always target distinct entries (unallocated slot,
  // oldest unfilled slot, filled head), so they can all happen together.
  always_comb begin
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    count_d    = count_q + CW'(alloc_i) - CW'(free_i);
    unfilled_d = unfilled_q + CW'(alloc_i) - CW'(fill_en);
    if (alloc_i) alloc_d = alloc_q + AW'(1);
    if (fill_en) fill_d  = fill_q + AW'(1);
    if (free_i)  head_d  = head_q + AW'(1);
    if (flush_i) begin
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      if (!flush_i) begin
        if (alloc_i) begin
          ent_q[alloc_q].pc     <= alloc_pc_i;
          ent_q[alloc_q].filled <= 1'b0;
        end
        if (fill_en) begin
          ent_q[fill_q].instr  <= fill_instr_i;
          ent_q[fill_q].filled <= 1'b1;
        end
      end
    end
  end

  assign head_ready_o = (count_q != '0) && ent_q[head_q].filled;
  assign head_pc_o    = ent_q[head_q].pc;
  assign head_instr_o = ent_q[head_q].instr;
  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect support.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// imem response channel has no ready and must be accepted whenever valid.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   redirect_valid/redirect_pc  : flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr   : fetch request to instruction memory
//   imem_rsp_valid/instr        : in-order responses from memory
//   out_valid/ready             : instruction handshake towards decode
//   out_instr/out_pc/out_pc_next: instruction, its PC and PC+PC_STEP
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = FETCH_PC_W,
  parameter int INSTR_W  = FETCH_INSTR_W,
  parameter int PC_STEP  = FETCH_PC_STEP,
  parameter int RESET_PC = FETCH_RESET_PC,
  parameter int DEPTH    = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_next
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic [CW-1:0]      count, unfilled;
  logic               head_ready;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [CW:0]        occupancy;
  logic               req_fire, out_fire, rsp_fill, rsp_outstanding;

  // Requests still in flight for flushed entries occupy memory-side slots,
  // so they count against the queue depth until their responses drain.
  assign occupancy      = {1'b0, count} + {1'b0, discard_q};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = !rst && !redirect_valid && head_ready;
  assign out_fire  = out_valid && out_ready;

  assign rsp_fill        = !rst && !redirect_valid && imem_rsp_valid && (discard_q == '0);
  // A response consumes one in-flight request only if one actually exists.
  assign rsp_outstanding = imem_rsp_valid && ((discard_q != '0) || (unfilled != '0));

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      // Everything still in flight after this cycle must be dropped.
      discard_d = discard_q + unfilled + CW'(req_fire) - CW'(rsp_outstanding);
    end else begin
      if (req_fire) pc_d = pc_q + PC_W'(PC_STEP);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_W'(RESET_PC);
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_queue #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (redirect_valid),
    .alloc_i      (req_fire),
    .alloc_pc_i   (pc_q),
    .fill_i       (rsp_fill),
    .fill_instr_i (imem_rsp_instr),
    .free_i       (out_fire),
    .head_ready_o (head_ready),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  // Outputs read zero throughout reset, including its first cycle.
  assign out_instr   = rst ? '0 : head_instr;
  assign out_pc      = rst ? '0 : head_pc;
  assign out_pc_next = rst ? '0 : head_pc + PC_W'(PC_STEP);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a
// queue-based behavioural model, plus a second instance with RESET_PC=0xFFFC
// to cover PC wrap-around.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        rst, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, out_valid, out_ready;
  logic [15:0] redirect_pc, imem_req_addr, out_pc, out_pc_next;
  logic [31:0] imem_rsp_instr, out_instr;

  fetch_unit #(.RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next)
  );

  // ---------------- wrap DUT ----------------
  logic        w_rst, w_redir, w_req_valid, w_req_ready, w_rsp_valid, w_out_valid, w_out_ready;
  logic [15:0] w_rpc, w_req_addr, w_out_pc, w_out_pc_next;
  logic [31:0] w_rsp_instr, w_out_instr;

  fetch_unit #(.RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_instr(w_rsp_instr),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .out_pc_next(w_out_pc_next)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Behavioural model: entries in program order; the filled ones form a prefix.
  logic [15:0] m_pc;
  logic [15:0] m_epc[$];
  logic [31:0] exp_q[$];   // instructions of filled entries, oldest first
  int          m_disc;
  logic [15:0] mem_q[$];   // addresses accepted by memory, not yet answered

  bit          obs_rv, obs_ov, obs_fire;
  logic [15:0] obs_addr, obs_pc, obs_pcn;
  logic [31:0] obs_instr;

  // ---------------- driver + per-cycle compare ----------------
  // Entered just after a rising edge; returns just after the next one.
  task automatic step(input bit r, input bit rd, input logic [15:0] rpc,
                      input int p_rdy, input int p_rsp, input bit ordy);
    bit          e_rv, e_ov, fire, ofire, do_fill;
    logic [15:0] e_pcn;
    int          outst;
    rst            = r;
    redirect_valid = rd;
    redirect_pc    = rpc;
    out_ready      = ordy;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    imem_rsp_valid = 1'b0;
    imem_rsp_instr = $urandom;
    if (mem_q.size() > 0) begin
      if ($urandom_range(99) < p_rsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_instr = mk_instr(mem_q.pop_front());
      end
    end else if ($urandom_range(99) < 10) begin
      imem_rsp_valid = 1'b1;   // spurious response, must be ignored
    end

    @(negedge clk);
    obs_rv = imem_req_valid; obs_ov = out_valid; obs_addr = imem_req_addr;
    obs_pc = out_pc; obs_pcn = out_pc_next; obs_instr = out_instr;
    obs_fire = imem_req_valid && imem_req_ready;

    e_rv = !r && !rd && (m_epc.size() + m_disc < DEPTH);
    e_ov = !r && !rd && (exp_q.size() > 0);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", 32'(imem_req_addr), 32'(m_pc));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (r) begin
      chk("rst_out_pc", 32'(out_pc), 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc_next", 32'(out_pc_next), 32'h0);
    end else if (e_ov) begin
      e_pcn = m_epc[0] + 16'd4;
      chk("out_pc", 32'(out_pc), 32'(m_epc[0]));
      chk("out_instr", out_instr, exp_q[0]);
      chk("out_pc_next", 32'(out_pc_next), 32'(e_pcn));
    end

    fire  = e_rv && imem_req_ready;
    ofire = e_ov && ordy;
    if (r) begin
      m_pc = 16'h0000; m_epc.delete(); exp_q.delete(); m_disc = 0; mem_q.delete();
    end else if (rd) begin
      outst = m_disc + (m_epc.size() - exp_q.size());
      if (imem_rsp_valid && outst > 0) outst--;
      m_disc = outst; m_epc.delete(); exp_q.delete(); m_pc = rpc;
    end else begin
      do_fill = imem_rsp_valid && m_disc == 0 && exp_q.size() < m_epc.size();
      if (imem_rsp_valid && m_disc > 0) m_disc--;
      if (do_fill) exp_q.push_back(imem_rsp_instr);
      if (ofire) begin void'(m_epc.pop_front()); void'(exp_q.pop_front()); end
      if (fire) begin m_epc.push_back(m_pc); mem_q.push_back(m_pc); m_pc = m_pc + 16'd4; end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- wrap instance driver ----------------
  bit wdone = 1'b0;
  initial begin
    int          nseen;
    bit          wf;
    logic [15:0] wa;
    nseen = 0;
    w_rst = 1'b1; w_redir = 1'b0; w_rpc = '0; w_req_ready = 1'b1;
    w_rsp_valid = 1'b0; w_rsp_instr = '0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 w_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (w_out_valid && nseen == 0) begin
        chk("wrap_pc0", 32'(w_out_pc), 32'h0000FFFC);
        chk("wrap_pcn0", 32'(w_out_pc_next), 32'h00000000);
        chk("wrap_instr0", w_out_instr, 32'h0003FFFC);
        nseen++;
      end else if (w_out_valid && nseen == 1) begin
        chk("wrap_pc1", 32'(w_out_pc), 32'h00000000);
        chk("wrap_pcn1", 32'(w_out_pc_next), 32'h00000004);
        nseen++;
      end
      wf = w_req_valid && w_req_ready;
      wa = w_req_addr;
      @(posedge clk);
      #1;
      w_rsp_valid = wf;
      w_rsp_instr = mk_instr(wa);
    end
    chk("wrap_seen", 32'(nseen), 32'd2);
    wdone = 1'b1;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int nf;
    bit found;
    m_pc = '0; m_disc = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_instr = '0;
    @(posedge clk);
    #1;

    // Reset, then zero-latency memory with decode always ready.
    repeat (3) step(1, 0, 16'h0, 100, 100, 1);
    chk("rst_req_valid_low", 32'(obs_rv), 32'd0);
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 16'h0, 100, 100, 1);
      if (c == 0) begin
        chk("first_req", 32'(obs_fire), 32'd1);
        chk("first_addr", 32'(obs_addr), 32'h0);
      end
      if (c == 1) chk("fill_gap", 32'(obs_ov), 32'd0);
      if (c >= 2) begin
        chk("stream_valid", 32'(obs_ov), 32'd1);
        chk("stream_pc", 32'(obs_pc), 32'((c - 2) * 4));
      end
    end

    // Decode frozen: exactly DEPTH requests, then drain in order.
    repeat (2) step(1, 0, 16'h0, 100, 100, 1);
    nf = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 16'h0, 100, 100, 0);
      if (obs_fire) nf++;
    end
    chk("freeze_req_count", 32'(nf), 32'd4);
    chk("freeze_req_low", 32'(obs_rv), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 16'h0, 100, 100, 1);
      chk("drain_pc", 32'(obs_pc), 32'(c * 4));
      if (c == 0) chk("drain_req_still_low", 32'(obs_rv), 32'd0);
      if (c == 1) chk("fetch_resumes", 32'(obs_rv), 32'd1);
    end

    // Redirect with three requests outstanding.
    repeat (2) step(1, 0, 16'h0, 100, 100, 1);
    repeat (3) step(0, 0, 16'h0, 100, 0, 1);
    step(0, 1, 16'h0100, 100, 0, 1);
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(0, 0, 16'h0, 100, 100, 1);
      if (obs_ov && !found) begin
        chk("redir_pc", 32'(obs_pc), 32'h0100);
        chk("redir_pcn", 32'(obs_pcn), 32'h0104);
        found = 1'b1;
      end
    end
    chk("redir_seen", 32'(found), 32'd1);

    // Back-to-back redirects: the last target wins.
    repeat (2) step(0, 0, 16'h0, 100, 50, 1);
    step(0, 1, 16'h0200, 100, 50, 1);
    step(0, 1, 16'h0300, 100, 50, 1);
    found = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step(0, 0, 16'h0, 100, 100, 1);
      if (obs_ov && !found) begin
        chk("b2b_redir_pc", 32'(obs_pc), 32'h0300);
        found = 1'b1;
      end
    end
    chk("b2b_redir_seen", 32'(found), 32'd1);

    // Reset mid-stream with the queue full and two responses pending.
    repeat (2) step(1, 0, 16'h0, 100, 100, 1);
    repeat (3) step(0, 0, 16'h0, 100, 100, 0);
    repeat (3) step(0, 0, 16'h0, 100, 0, 0);
    chk("full_req_low", 32'(obs_rv), 32'd0);
    chk("pre_rst_out_valid", 32'(obs_ov), 32'd1);
    step(1, 0, 16'h0, 100, 100, 1);
    chk("rst_kills_out_valid", 32'(obs_ov), 32'd0);
    step(1, 0, 16'h0, 100, 100, 1);
    step(0, 0, 16'h0, 100, 100, 1);
    chk("post_rst_req", 32'(obs_fire), 32'd1);
    chk("post_rst_addr", 32'(obs_addr), 32'h0);
    repeat (6) step(0, 0, 16'h0, 100, 100, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] rpc;
      rpc = 16'($urandom) & 16'hFFFC;
      step($urandom_range(99) < 1, $urandom_range(99) < 5, rpc,
           70, 60, $urandom_range(99) < 70);
    end

    for (int c = 0; c < 100 && !wdone; c++) @(posedge clk);
    chk("wrap_done", 32'(wdone), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
